// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, captures the combinational
// memory read into a small circular buffer and hands {pc, instr} to decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    localparam int         CW       = $clog2(DEPTH + 1),
    localparam int         PW       = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [31:0]   io_imem_address,
    input  logic [31:0]   io_imem_instruction,
    input  logic          io_redirect_valid,
    input  logic [31:0]   io_redirect_pc,
    output logic          io_out_valid,
    input  logic          io_out_ready,
    output logic [31:0]   io_out_pc,
    output logic [31:0]   io_out_instruction,
    output logic [CW-1:0] io_count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;

    logic          w_deq;
    logic          w_enq;
    logic [CW-1:0] w_count_next;
    logic          w_unused_ok;

    // Redirect targets are word-aligned; the low bits are simply dropped.
    assign w_unused_ok = &{1'b0, io_redirect_pc[1:0]};

    assign w_deq = (r_count != '0) && io_out_ready;
    // A full buffer can still accept when the head leaves on the same edge.
    assign w_enq = !io_redirect_valid && ((r_count < FULL) || w_deq);

    always_comb begin
        w_count_next = r_count;
        if (w_enq && !w_deq)
            w_count_next = r_count + CW'(1);
        else if (!w_enq && w_deq)
            w_count_next = r_count - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (io_redirect_valid) begin
            r_pc    <= {io_redirect_pc[31:2], 2'b00};
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wr <= r_wr + PW'(1);
                r_pc <= r_pc + 32'd4;
            end
            if (w_deq)
                r_rd <= r_rd + PW'(1);
            r_count <= w_count_next;
        end
    end

    // Storage needs no reset; entries are only visible once counted.
    always_ff @(posedge clock) begin
        if (reset && w_enq) begin
            r_mem_pc[r_wr]    <= r_pc;
            r_mem_instr[r_wr] <= io_imem_instruction;
        end
    end

    assign io_imem_address    = r_pc;
    assign io_out_valid       = (r_count != '0);
    assign io_out_pc          = r_mem_pc[r_rd];
    assign io_out_instruction = r_mem_instr[r_rd];
    assign io_count           = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based reference model compared every
// cycle, plus literal expectations along the documented scenarios.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          CW       = $clog2(DEPTH + 1);

    logic          clock;
    logic          reset;
    logic [31:0]   io_imem_address;
    logic [31:0]   io_imem_instruction;
    logic          io_redirect_valid;
    logic [31:0]   io_redirect_pc;
    logic          io_out_valid;
    logic          io_out_ready;
    logic [31:0]   io_out_pc;
    logic [31:0]   io_out_instruction;
    logic [CW-1:0] io_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_pcq[$];
    logic [31:0] m_inq[$];
    logic [31:0] dut_taken[$];

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock               (clock),
        .reset               (reset),
        .io_imem_address     (io_imem_address),
        .io_imem_instruction (io_imem_instruction),
        .io_redirect_valid   (io_redirect_valid),
        .io_redirect_pc      (io_redirect_pc),
        .io_out_valid        (io_out_valid),
        .io_out_ready        (io_out_ready),
        .io_out_pc           (io_out_pc),
        .io_out_instruction  (io_out_instruction),
        .io_count            (io_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000 + {2'b00, a[31:2]};
    endfunction

    assign io_imem_instruction = mem_word(io_imem_address);

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of fetched entries and a fetch PC.
    always @(posedge clock) begin
        if (!reset) begin
            m_pcq.delete();
            m_inq.delete();
            m_pc = RESET_PC;
        end else if (io_redirect_valid) begin
            m_pcq.delete();
            m_inq.delete();
            m_pc = io_redirect_pc & 32'hFFFF_FFFC;
        end else begin
            bit d;
            bit e;
            d = (m_pcq.size() != 0) && io_out_ready;
            e = (m_pcq.size() < DEPTH) || d;
            if (d) begin
                void'(m_pcq.pop_front());
                void'(m_inq.pop_front());
            end
            if (e) begin
                m_pcq.push_back(m_pc);
                m_inq.push_back(mem_word(m_pc));
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("imem_address", io_imem_address, m_pc);
            chk("out_valid", {31'b0, io_out_valid}, {31'b0, m_pcq.size() != 0});
            chk("count", {{(32-CW){1'b0}}, io_count}, m_pcq.size());
            if (m_pcq.size() != 0) begin
                chk("out_pc", io_out_pc, m_pcq[0]);
                chk("out_instruction", io_out_instruction, m_inq[0]);
            end
            if (reset && io_out_valid && io_out_ready)
                dut_taken.push_back(io_out_pc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lit(input logic [CW-1:0] cnt, input logic vld, input logic [31:0] addr, string tag);
        chk({tag, ".count"}, {{(32-CW){1'b0}}, io_count}, {{(32-CW){1'b0}}, cnt});
        chk({tag, ".valid"}, {31'b0, io_out_valid}, {31'b0, vld});
        chk({tag, ".addr"}, io_imem_address, addr);
    endtask

    initial begin
        int base;
        reset = 0;
        io_redirect_valid = 0;
        io_redirect_pc = 0;
        io_out_ready = 1;

        tick();
        chk_en = 1;
        tick();
        lit(0, 0, 32'h0, "reset");

        // Reset then stream
        reset = 1;
        tick();
        lit(1, 1, 32'h4, "stream0");
        chk("stream0.pc", io_out_pc, 32'h0);
        chk("stream0.instr", io_out_instruction, 32'h1000);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("stream.pc", io_out_pc, 32'(4 * i));
            chk("stream.instr", io_out_instruction, 32'h1000 + 32'(i));
            chk("stream.count", {{(32-CW){1'b0}}, io_count}, 32'd1);
        end

        // Fill and stall
        reset = 0;
        tick();
        reset = 1;
        io_out_ready = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("fill.count", {{(32-CW){1'b0}}, io_count}, (i < 4) ? 32'(i) : 32'd4);
        end
        lit(4, 1, 32'h10, "full");

        // Full plus pop, then drain with no gap or duplicate
        base = dut_taken.size();
        io_out_ready = 1;
        tick();
        lit(4, 1, 32'h14, "fullpop");
        chk("fullpop.taken", dut_taken[base], 32'h0);
        chk("fullpop.head", io_out_pc, 32'h4);
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 5; i++)
            chk("drain.seq", dut_taken[base + i], 32'(4 * i));

        // Redirect during streaming
        base = dut_taken.size();
        begin
            logic [31:0] head;
            head = io_out_pc;
            io_redirect_valid = 1;
            io_redirect_pc = 32'h203;
            tick();
            chk("redir.handshake", dut_taken[base], head);
        end
        lit(0, 0, 32'h200, "redir");
        io_redirect_valid = 0;
        tick();
        lit(1, 1, 32'h204, "redir1");
        chk("redir1.pc", io_out_pc, 32'h200);
        tick();
        chk("redir2.pc", io_out_pc, 32'h204);

        // Back-to-back redirects
        io_redirect_valid = 1;
        io_redirect_pc = 32'h400;
        tick();
        chk("b2b.valid0", {31'b0, io_out_valid}, 32'd0);
        io_redirect_pc = 32'h501;
        tick();
        lit(0, 0, 32'h500, "b2b");
        io_redirect_valid = 0;
        tick();
        chk("b2b.pc", io_out_pc, 32'h500);

        // Address wrap
        io_redirect_valid = 1;
        io_redirect_pc = 32'hFFFF_FFF8;
        tick();
        io_redirect_valid = 0;
        tick();
        chk("wrap.pc0", io_out_pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap.pc1", io_out_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap.pc2", io_out_pc, 32'h0000_0000);

        // Reset mid-operation overrides redirect and handshake
        io_out_ready = 0;
        io_redirect_valid = 1;
        io_redirect_pc = 32'h800;
        tick();
        io_redirect_valid = 0;
        tick();
        tick();
        tick();
        lit(3, 1, 32'h80C, "mid");
        reset = 0;
        io_redirect_valid = 1;
        io_out_ready = 1;
        tick();
        lit(0, 0, RESET_PC, "midrst");
        reset = 1;
        io_redirect_valid = 0;
        tick();
        chk("midrst.pc", io_out_pc, RESET_PC);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
